axi_mst_aw_gen: RTL

Testbench-side AXI master write-address generator. It sits directly upstream of the master W-channel driver. It issues randomized INCR AW requests with IDs {MST_ID, slot} and bounds outstanding writes to MST_OSTDREQ_NUM. It retires IDs on B handshakes and flags protocol errors. It feeds awvalid/awready/awlen/awid to the W driver and to the crossbar slave port.

---
 rtl/axi_mst_aw_gen.sv | 138 +++++++++++++
 1 files changed

// File: rtl/axi_mst_aw_gen.sv
// axi_mst_aw_gen: randomized INCR write-address generator with per-slot outstanding tracking and B-channel checks
module axi_mst_aw_gen #(
    parameter int                  AXI_ADDR_W      = 32,
    parameter int                  AXI_ID_W        = 4,
    parameter logic [AXI_ID_W-3:0] MST_ID          = 2'b01,
    parameter int                  MST_OSTDREQ_NUM = 4,
    parameter logic [3:0]          LEN_MASK        = 4'hF,
    parameter int                  NUM_REQ         = 16,
    parameter logic [31:0]         LFSR_SEED       = 32'h1ACE_B00C
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  srst,
    input  logic                  start,
    input  logic                  narrow,
    output logic                  out_awvalid,
    input  logic                  in_awready,
    output logic [AXI_ADDR_W-1:0] out_awaddr,
    output logic [7:0]            out_awlen,
    output logic [2:0]            out_awsize,
    output logic [1:0]            out_awburst,
    output logic [AXI_ID_W-1:0]   out_awid,
    input  logic                  in_bvalid,
    input  logic                  in_bready,
    input  logic [AXI_ID_W-1:0]   in_bid,
    input  logic [1:0]            in_bresp,
    output logic [2:0]            ostd_cnt,
    output logic [7:0]            issued_cnt,
    output logic                  done,
    output logic                  err_unexp,
    output logic                  err_resp
);
    typedef enum logic [2:0] {IDLE, GAP, REQ, DRAIN, DONE} state_t;
    state_t                     state, state_d;
    logic [31:0]                lfsr, lfsr_d, lfsr_step;
    logic [MST_OSTDREQ_NUM-1:0] busy, busy_d, alloc, freed;
    logic [1:0]                 gap, gap_d, free_slot;
    logic [7:0]                 issued_d, len_d;
    logic [AXI_ADDR_W-1:0]      addr_d;
    logic [2:0]                 size_d;
    logic [AXI_ID_W-1:0]        id_d;
    logic                       unexp_d, resp_d, aw_hs, b_hs, b_ok, clr;

    assign aw_hs       = out_awvalid && in_awready;
    assign b_hs        = in_bvalid && in_bready;
    assign b_ok        = in_bid[AXI_ID_W-1:2] == MST_ID && busy[in_bid[1:0]];
    assign clr         = (state == IDLE || state == DONE) && start;
    assign lfsr_step   = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
    // allocation and release touch different slots, so one combined update suffices
    assign alloc       = aw_hs ? MST_OSTDREQ_NUM'(1) << out_awid[1:0] : '0;
    assign freed       = b_hs && b_ok ? MST_OSTDREQ_NUM'(1) << in_bid[1:0] : '0;
    assign out_awvalid = state == REQ;
    assign out_awburst = 2'b01;
    assign done        = state == DONE;
    assign ostd_cnt    = 3'($countones(busy));

    always_comb begin
        free_slot = '0;
        for (int i = MST_OSTDREQ_NUM - 1; i >= 0; i--) if (!busy[i]) free_slot = 2'(i);
    end

    always_comb begin
        state_d  = state;
        gap_d    = gap;
        lfsr_d   = lfsr;
        issued_d = clr ? 8'd0 : issued_cnt;
        addr_d   = out_awaddr;
        len_d    = out_awlen;
        size_d   = out_awsize;
        id_d     = out_awid;
        busy_d   = (busy | alloc) & ~freed;
        unexp_d  = (err_unexp && !clr) || (b_hs && !b_ok);
        resp_d   = (err_resp && !clr) || (b_hs && in_bresp != 2'b00);
        case (state)
            IDLE, DONE: if (start) begin
                state_d = GAP;
                gap_d   = lfsr[31:30];
            end
            GAP: if (gap != 2'd0) gap_d = gap - 2'd1;
            else if (!(&busy) && issued_cnt < 8'(NUM_REQ)) begin
                state_d = REQ;
                addr_d  = {lfsr[AXI_ADDR_W-1:6], 6'b0};
                len_d   = {4'b0, lfsr[3:0] & LEN_MASK};
                size_d  = narrow ? 3'd0 : 3'd2;
                id_d    = {MST_ID, free_slot};
            end
            REQ: if (aw_hs) begin
                lfsr_d   = lfsr_step;
                issued_d = issued_cnt + 8'd1;
                gap_d    = lfsr_step[31:30];
                state_d  = issued_cnt + 8'd1 == 8'(NUM_REQ) ? DRAIN : GAP;
            end
            DRAIN: if (busy == '0) state_d = DONE;
            default: ;
        endcase
        if (srst) begin
            state_d  = IDLE;
            gap_d    = '0;
            lfsr_d   = LFSR_SEED;
            issued_d = '0;
            addr_d   = '0;
            len_d    = '0;
            size_d   = '0;
            id_d     = '0;
            busy_d   = '0;
            unexp_d  = 1'b0;
            resp_d   = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            gap        <= '0;
            lfsr       <= LFSR_SEED;
            issued_cnt <= '0;
            out_awaddr <= '0;
            out_awlen  <= '0;
            out_awsize <= '0;
            out_awid   <= '0;
            busy       <= '0;
            err_unexp  <= 1'b0;
            err_resp   <= 1'b0;
        end else begin
            state      <= state_d;
            gap        <= gap_d;
            lfsr       <= lfsr_d;
            issued_cnt <= issued_d;
            out_awaddr <= addr_d;
            out_awlen  <= len_d;
            out_awsize <= size_d;
            out_awid   <= id_d;
            busy       <= busy_d;
            err_unexp  <= unexp_d;
            err_resp   <= resp_d;
        end
    end
endmodule
